// File: rtl/phys_free_list.sv
// Physical-register free list for the rename stage.
//
// Circular buffer of DEPTH tags. The head pointer hands tags to rename; the
// tail pointer takes back tags released at retirement. Both pointers carry a
// phase bit above the index, so full and empty can be told apart. The head
// can be rolled back in one cycle to a snapshot taken at a branch.
//
// Ports:
//   clk, rst_n     clock; asynchronous active-low reset
//   alloc_req      rename wants one tag this cycle
//   alloc_valid    a tag is available (low when empty or restoring)
//   alloc_tag      tag at the head
//   free_valid     retirement returns free_tag this cycle
//   free_tag       tag being returned
//   snapshot_ptr   current head pointer, for branch checkpoints
//   restore_valid  roll the head back to restore_ptr
//   restore_ptr    previously captured snapshot_ptr
//   free_count     number of tags held
//   overflow_err   sticky: a free arrived while the list was full
module phys_free_list #(
    parameter int unsigned NUM_PRS    = 32,
    parameter int unsigned NUM_LRS    = 10,
    parameter int unsigned ADDR_WIDTH = 5,
    localparam int unsigned DEPTH     = NUM_PRS - NUM_LRS,
    localparam int unsigned PTR_W     = $clog2(DEPTH) + 1,
    localparam int unsigned CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alloc_req,
    output logic                  alloc_valid,
    output logic [ADDR_WIDTH-1:0] alloc_tag,
    input  logic                  free_valid,
    input  logic [ADDR_WIDTH-1:0] free_tag,
    output logic [PTR_W-1:0]      snapshot_ptr,
    input  logic                  restore_valid,
    input  logic [PTR_W-1:0]      restore_ptr,
    output logic [CNT_W-1:0]      free_count,
    output logic                  overflow_err
);

    localparam int unsigned IDX_W = PTR_W - 1;

    logic [ADDR_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      head_q, head_d;
    logic [PTR_W-1:0]      tail_q, tail_d;
    logic                  overflow_q, overflow_d;

    logic                  empty, full;
    logic                  alloc_fire, free_fire;
    logic [IDX_W-1:0]      head_idx, tail_idx;
    logic                  head_phase, tail_phase;
    logic [CNT_W-1:0]      idx_diff;

    // Index wraps at DEPTH-1 (not a power of two), toggling the phase bit.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] r;
        if (p[IDX_W-1:0] == IDX_W'(DEPTH - 1)) begin
            r = {~p[PTR_W-1], {IDX_W{1'b0}}};
        end else begin
            r = {p[PTR_W-1], p[IDX_W-1:0] + IDX_W'(1)};
        end
        return r;
    endfunction

    always_comb begin
        head_idx   = head_q[IDX_W-1:0];
        tail_idx   = tail_q[IDX_W-1:0];
        head_phase = head_q[PTR_W-1];
        tail_phase = tail_q[PTR_W-1];

        empty = (head_q == tail_q);
        full  = (head_idx == tail_idx) && (head_phase != tail_phase);

        alloc_valid = !empty && !restore_valid;
        alloc_fire  = alloc_req && alloc_valid;
        free_fire   = free_valid && !full;

        head_d = head_q;
        if (restore_valid) begin
            head_d = restore_ptr;
        end else if (alloc_fire) begin
            head_d = ptr_inc(head_q);
        end

        tail_d = tail_q;
        if (free_fire) begin
            tail_d = ptr_inc(tail_q);
        end

        overflow_d = overflow_q | (free_valid & full);

        // Modular subtraction; adding DEPTH when phases differ gives the
        // true count in 0..DEPTH.
        idx_diff = CNT_W'(tail_idx) - CNT_W'(head_idx);
        if (head_phase != tail_phase) begin
            free_count = idx_diff + CNT_W'(DEPTH);
        end else begin
            free_count = idx_diff;
        end

        alloc_tag    = mem_q[head_idx];
        snapshot_ptr = head_q;
        overflow_err = overflow_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q     <= '0;
            tail_q     <= {1'b1, {IDX_W{1'b0}}};
            overflow_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            overflow_q <= overflow_d;
        end
    end

    // Out of reset the list holds every tag not used by the architectural map.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= ADDR_WIDTH'(NUM_LRS + unsigned'(i));
            end
        end else if (free_fire) begin
            mem_q[tail_idx] <= free_tag;
        end
    end

endmodule

// File: tb/tb_phys_free_list.sv
module tb_phys_free_list;

    logic       clk;
    logic       rst_n;
    logic       alloc_req;
    logic       alloc_valid;
    logic [4:0] alloc_tag;
    logic       free_valid;
    logic [4:0] free_tag;
    logic [5:0] snapshot_ptr;
    logic       restore_valid;
    logic [5:0] restore_ptr;
    logic [4:0] free_count;
    logic       overflow_err;

    int         n_tests;
    int         n_fail;
    int         exp_q[$];
    logic [5:0] snap;

    phys_free_list dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .alloc_req    (alloc_req),
        .alloc_valid  (alloc_valid),
        .alloc_tag    (alloc_tag),
        .free_valid   (free_valid),
        .free_tag     (free_tag),
        .snapshot_ptr (snapshot_ptr),
        .restore_valid(restore_valid),
        .restore_ptr  (restore_ptr),
        .free_count   (free_count),
        .overflow_err (overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock cycle of stimulus. Inputs are driven 1 time unit after the
    // rising edge; combinational outputs are checked 1 unit later, and a fire
    // pops the scoreboard and compares the issued tag.
    task automatic step(input logic a_req, input logic f_v, input int f_tag,
                        input logic r_v, input logic [5:0] r_ptr, input logic exp_fire);
        alloc_req     = a_req;
        free_valid    = f_v;
        free_tag      = 5'(f_tag);
        restore_valid = r_v;
        restore_ptr   = r_ptr;
        #1;
        if (a_req) begin
            check("fire", int'(alloc_valid), int'(exp_fire));
            if (alloc_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_fire", 1, 0);
                end else begin
                    check("alloc_tag", int'(alloc_tag), exp_q.pop_front());
                end
            end
        end
        @(posedge clk);
        #1;
        alloc_req     = 1'b0;
        free_valid    = 1'b0;
        restore_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #12;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        alloc_req     = 1'b0;
        free_valid    = 1'b0;
        free_tag      = '0;
        restore_valid = 1'b0;
        restore_ptr   = '0;

        // Reset state
        do_reset();
        #1;
        check("rst_free_count", int'(free_count), 22);
        check("rst_alloc_tag", int'(alloc_tag), 10);
        check("rst_alloc_valid", int'(alloc_valid), 1);
        check("rst_snapshot", int'(snapshot_ptr), 0);
        check("rst_overflow", int'(overflow_err), 0);

        // Drain all 22 tags in order
        for (int t = 10; t <= 31; t++) exp_q.push_back(t);
        for (int i = 0; i < 22; i++) step(1, 0, 0, 0, '0, 1);
        check("empty_valid", int'(alloc_valid), 0);
        check("empty_count", int'(free_count), 0);
        step(1, 0, 0, 0, '0, 0);
        check("empty_count_after_req", int'(free_count), 0);

        // Free into empty: no bypass, issued next cycle
        step(1, 1, 5, 0, '0, 0);
        check("after_free_count", int'(free_count), 1);
        exp_q.push_back(5);
        step(1, 0, 0, 0, '0, 1);
        check("after_realloc_count", int'(free_count), 0);

        // Snapshot / restore
        do_reset();
        snap = snapshot_ptr;
        check("snap_value", int'(snap), 0);
        for (int t = 10; t <= 12; t++) exp_q.push_back(t);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, '0, 1);
        check("pre_restore_count", int'(free_count), 19);
        check("pre_restore_snapshot", int'(snapshot_ptr), 3);
        step(1, 0, 0, 1, snap, 0);
        check("restore_tag", int'(alloc_tag), 10);
        check("restore_count", int'(free_count), 22);

        // Bring list down to 4 held tags (28..31 left)
        for (int t = 10; t <= 27; t++) exp_q.push_back(t);
        for (int i = 0; i < 18; i++) step(1, 0, 0, 0, '0, 1);
        check("four_count", int'(free_count), 4);

        // Simultaneous alloc + free keeps the count
        for (int t = 28; t <= 30; t++) exp_q.push_back(t);
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 3, 0, '0, 1);
            check("simul_count", int'(free_count), 4);
        end
        exp_q.push_back(31);
        for (int i = 0; i < 3; i++) exp_q.push_back(3);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, '0, 1);
        check("drained_count", int'(free_count), 0);
        check("drained_valid", int'(alloc_valid), 0);
        check("scoreboard_empty", exp_q.size(), 0);

        // Free while full sets the sticky error
        do_reset();
        step(0, 1, 7, 0, '0, 0);
        check("ovf_err", int'(overflow_err), 1);
        check("ovf_count", int'(free_count), 22);
        check("ovf_tag", int'(alloc_tag), 10);
        step(0, 0, 0, 0, '0, 0);
        check("ovf_sticky", int'(overflow_err), 1);
        exp_q.push_back(10);
        step(1, 0, 0, 0, '0, 1);
        check("ovf_alloc_count", int'(free_count), 21);

        // Asynchronous reset mid-cycle
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_err", int'(overflow_err), 0);
        check("async_rst_tag", int'(alloc_tag), 10);
        check("async_rst_count", int'(free_count), 22);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("post_rst_valid", int'(alloc_valid), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
